simt_reconvergence_stack: RTL and testbench
===========================================

Name: simt_reconvergence_stack

Overview:
- Parametrised SIMT divergence/reconvergence unit: generalises the single-entry sync/mask stack used by the vector datapath to configurable THREADS, DEPTH and ADDR_W.
- Sits beside the PC logic. It decides per branch whether execution is uniform or divergent and owns the active thread mask.
- It redirects the PC to the deferred path when execution reaches the reconvergence point, then restores the pre-divergence mask.
- Two-phase entries support if/else: the fall-through path runs first, then the taken path.

Parameters:
- THREADS, 4, number of SIMT lanes (mask width).
- DEPTH, 8, maximum nesting depth (stack entries).
- ADDR_W, 32, PC width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, synchronous, active-low.
- adv  in  1  PC advances this cycle (iHit & !halt); all state updates are gated by adv.
- br_valid  in  1  current instruction is a vector branch.
- br_cond  in  THREADS  per-lane branch-taken condition.
- br_target  in  ADDR_W  taken-path PC.
- br_reconv  in  ADDR_W  reconvergence (sync) PC from the instruction's sync register.
- pc_next  in  ADDR_W  sequential/fall-through next PC from the datapath.
- active_mask  out  THREADS  registered lane enable.
- take_branch  out  1  combinational; all active lanes are taken (uniform taken).
- redirect  out  1  combinational; the PC must load redirect_pc instead of pc_next.
- redirect_pc  out  ADDR_W  combinational redirect address.
- depth  out  $clog2(DEPTH+1)  valid entries.
- full  out  1  depth==DEPTH.
- empty  out  1  depth==0.
- overflow  out  1  sticky error flag.
- div_count  out  32  divergence counter (see optional feature).
- max_depth  out  $clog2(DEPTH+1)  high-water mark (see optional feature).

Behaviour:
- Entry format: {sync_pc, resume_pc, taken_mask, restore_mask, phase}. phase is 0 while the fall-through path runs and 1 while the taken path runs.
- Reset (nRST low at posedge CLK):
  - active_mask = all ones; depth = 0; overflow = 0; div_count = 0; max_depth = 0.
  - Stack contents are don't-care.
  - Reset mid-divergence discards all entries.
- Definitions: T = br_cond & active_mask; N = ~br_cond & active_mask.
- Uniform branch (br_valid, and T==0 or N==0): take_branch = (T!=0). No push; mask unchanged.
- Divergent branch (br_valid, T!=0, N!=0, adv, !full):
  - take_branch = 0.
  - Push {sync=br_reconv, resume=br_target, taken_mask=T, restore_mask=active_mask, phase=0}.
  - active_mask <= N.
- Empty else-path (divergent and pc_next==br_reconv):
  - Push with phase=1.
  - redirect = 1, redirect_pc = br_target.
  - active_mask <= T, same cycle.
- Reconvergence match: !empty, adv, !(divergent push this cycle), and pc_next == top.sync_pc.
  - phase 0: redirect = 1, redirect_pc = top.resume_pc; active_mask <= top.taken_mask; top.phase <= 1.
  - phase 1: pop; active_mask <= top.restore_mask; redirect = 0 (execution continues at sync_pc = pc_next).
  - After a pop, the new top is checked on the next adv cycle only. Multiple pops to the same sync PC therefore take one cycle each; the caller holds pc_next there while the top still matches.
- Overflow: divergent branch while full.
  - overflow <= 1 (sticky until reset); no push; active_mask unchanged; take_branch = 0.
- adv low:
  - No state change.
  - redirect still evaluated combinationally, but ignored by the PC.
- br_valid has priority over reconvergence matching in the same cycle.
- Matching is never performed when empty, so underflow cannot occur.
- Latency:
  - active_mask changes the cycle after an adv edge.
  - redirect and take_branch are zero-latency combinational outputs.

Optional Feature:
- Macro: SIMT_STACK_STATS_EN.
- Defined:
  - div_count increments on each successful push, saturating at 32'hFFFF_FFFF.
  - max_depth tracks the maximum depth reached.
- Undefined:
  - div_count and max_depth are tied to 0.
  - No counter logic is present.

Test Plan:
- Reset then br_valid, br_cond=4'b1111 -> take_branch=1, no push, active_mask=4'b1111, depth=0.
- Divergent: br_cond=4'b0011, br_target=0x40, br_reconv=0x80 -> next cycle active_mask=4'b1100, depth=1.
  - Then pc_next=0x80 -> redirect=1, redirect_pc=0x40, active_mask=4'b0011.
  - pc_next=0x80 again -> pop, active_mask=4'b1111, depth=0.
- Nested: two divergences (masks 0011 then 0100 within 1100) -> depth=2. Pops unwind inner then outer; final active_mask=4'b1111.
- Empty else-path: br_cond=4'b0101, pc_next=br_reconv=0x20, br_target=0x10 -> same-cycle redirect to 0x10, next active_mask=4'b0101, phase=1. Next pc_next=0x20 -> pop to 4'b1111.
- DEPTH=2 overflow: three divergences -> overflow=1, depth=2, active_mask unchanged after the third branch.
- nRST low while depth=2 -> next cycle depth=0, active_mask=all ones, overflow=0. With SIMT_STACK_STATS_EN defined, div_count=0 after reset and 2 after two pushes.

Source files
------------

// File: rtl/simt_reconvergence_stack_if.sv
// simt_reconvergence_stack_if: branch/PC handshake between the PC logic and the reconvergence stack
interface simt_reconvergence_stack_if #(
  parameter int THREADS = 4,
  parameter int DEPTH = 8,
  parameter int ADDR_W = 32
);
  localparam int DW = $clog2(DEPTH + 1);
  logic adv;
  logic br_valid;
  logic [THREADS-1:0] br_cond;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] br_reconv;
  logic [ADDR_W-1:0] pc_next;
  logic [THREADS-1:0] active_mask;
  logic take_branch;
  logic redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [DW-1:0] depth;
  logic full;
  logic empty;
  logic overflow;
  logic [31:0] div_count;
  logic [DW-1:0] max_depth;
  modport master (
    output adv, br_valid, br_cond, br_target, br_reconv, pc_next,
    input active_mask, take_branch, redirect, redirect_pc, depth, full, empty, overflow, div_count, max_depth
  );
  modport slave (
    input adv, br_valid, br_cond, br_target, br_reconv, pc_next,
    output active_mask, take_branch, redirect, redirect_pc, depth, full, empty, overflow, div_count, max_depth
  );
endinterface

// File: rtl/simt_reconvergence_stack.sv
// simt_reconvergence_stack: SIMT divergence/reconvergence mask stack; SIMT_STACK_STATS_EN enables div_count/max_depth
module simt_reconvergence_stack #(
  parameter int THREADS = 4,
  parameter int DEPTH = 8,
  parameter int ADDR_W = 32
) (
  input logic CLK,
  input logic nRST,
  simt_reconvergence_stack_if.slave s
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [THREADS-1:0] r_mask;
  logic [DW-1:0] r_depth;
  logic r_ovf;
  logic [ADDR_W-1:0] r_sync [DEPTH];
  logic [ADDR_W-1:0] r_resume [DEPTH];
  logic [THREADS-1:0] r_tmask [DEPTH];
  logic [THREADS-1:0] r_rmask [DEPTH];
  logic [DEPTH-1:0] r_phase;
  logic [THREADS-1:0] w_t;
  logic [THREADS-1:0] w_n;
  logic [IW-1:0] w_top;
  logic [IW-1:0] w_wr;
  logic w_full;
  logic w_empty;
  logic w_div;
  logic w_push;
  logic w_else;
  logic w_match;
  logic w_ph;
  assign w_t = s.br_cond & r_mask;
  assign w_n = ~s.br_cond & r_mask;
  assign w_top = IW'(r_depth - 1'b1);
  assign w_wr = IW'(r_depth);
  assign w_full = r_depth == DW'(DEPTH);
  assign w_empty = r_depth == '0;
  assign w_div = s.br_valid && |w_t && |w_n;
  assign w_push = w_div && s.adv && !w_full;
  assign w_else = w_div && !w_full && s.pc_next == s.br_reconv;
  assign w_match = !w_empty && !s.br_valid && s.pc_next == r_sync[w_top];
  assign w_ph = r_phase[w_top];
  assign s.active_mask = r_mask;
  assign s.take_branch = s.br_valid && !w_div && |w_t;
  assign s.redirect = w_else || (w_match && !w_ph);
  assign s.redirect_pc = w_else ? s.br_target : r_resume[w_top];
  assign s.depth = r_depth;
  assign s.full = w_full;
  assign s.empty = w_empty;
  assign s.overflow = r_ovf;
  // mask, depth and sticky overflow: push on divergence, swap or pop on reconvergence
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_mask <= '1;
      r_depth <= '0;
      r_ovf <= 1'b0;
    end else if (s.adv) begin
      if (w_push) begin
        r_mask <= w_else ? w_t : w_n;
        r_depth <= r_depth + 1'b1;
      end else if (w_div) r_ovf <= 1'b1;
      else if (w_match) begin
        r_mask <= w_ph ? r_rmask[w_top] : r_tmask[w_top];
        if (w_ph) r_depth <= r_depth - 1'b1;
      end
    end
  end
  // entry storage; an empty else-path enters directly in the taken phase
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_sync[w_wr] <= s.br_reconv;
      r_resume[w_wr] <= s.br_target;
      r_tmask[w_wr] <= w_t;
      r_rmask[w_wr] <= r_mask;
      r_phase[w_wr] <= w_else;
    end else if (s.adv && w_match && !w_ph) r_phase[w_top] <= 1'b1;
  end
`ifdef SIMT_STACK_STATS_EN
  logic [31:0] r_div_count;
  logic [DW-1:0] r_max_depth;
  // saturating push counter and depth high-water mark
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_div_count <= '0;
      r_max_depth <= '0;
    end else begin
      if (w_push && r_div_count != '1) r_div_count <= r_div_count + 1'b1;
      if (r_depth > r_max_depth) r_max_depth <= r_depth;
    end
  end
  assign s.div_count = r_div_count;
  assign s.max_depth = r_max_depth;
`else
  assign s.div_count = '0;
  assign s.max_depth = '0;
`endif
endmodule

// File: tb/tb_simt_reconvergence_stack.sv
// tb_simt_reconvergence_stack: scoreboard bench for an 8-deep and a 2-deep stack
module tb_simt_reconvergence_stack;
  typedef struct {
    logic [3:0] mask;
    logic [3:0] depth;
    logic ovf;
  } st_t;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic adv = 1'b0;
  logic br_valid = 1'b0;
  logic [3:0] br_cond = '0;
  logic [31:0] br_target = '0;
  logic [31:0] br_reconv = '0;
  logic [31:0] pc_next = '0;
  int total = 0;
  int bad = 0;
  st_t q[$];
  simt_reconvergence_stack_if #(.THREADS(4), .DEPTH(8), .ADDR_W(32)) if0 ();
  simt_reconvergence_stack_if #(.THREADS(4), .DEPTH(2), .ADDR_W(32)) if1 ();
  assign if0.adv = adv;
  assign if0.br_valid = br_valid;
  assign if0.br_cond = br_cond;
  assign if0.br_target = br_target;
  assign if0.br_reconv = br_reconv;
  assign if0.pc_next = pc_next;
  assign if1.adv = adv;
  assign if1.br_valid = br_valid;
  assign if1.br_cond = br_cond;
  assign if1.br_target = br_target;
  assign if1.br_reconv = br_reconv;
  assign if1.pc_next = pc_next;
  simt_reconvergence_stack #(.THREADS(4), .DEPTH(8), .ADDR_W(32)) u0 (.CLK(CLK), .nRST(nRST), .s(if0.slave));
  simt_reconvergence_stack #(.THREADS(4), .DEPTH(2), .ADDR_W(32)) u1 (.CLK(CLK), .nRST(nRST), .s(if1.slave));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic stats(input bit sel, input logic [31:0] e_cnt, input logic [3:0] e_max);
`ifdef SIMT_STACK_STATS_EN
    chk("div_count", 64'(sel ? if1.div_count : if0.div_count), 64'(e_cnt));
    chk("max_depth", sel ? 64'(if1.max_depth) : 64'(if0.max_depth), 64'(e_max));
`else
    chk("div_count", 64'(sel ? if1.div_count : if0.div_count), 64'd0);
    chk("max_depth", sel ? 64'(if1.max_depth) : 64'(if0.max_depth), 64'd0);
`endif
  endtask
  task automatic do_reset(input bit sel);
    @(negedge CLK);
    nRST = 1'b0;
    adv = 1'b0;
    br_valid = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    chk("rst_mask", 64'(sel ? if1.active_mask : if0.active_mask), 64'hF);
    chk("rst_depth", sel ? 64'(if1.depth) : 64'(if0.depth), 64'd0);
    chk("rst_empty", 64'(sel ? if1.empty : if0.empty), 64'd1);
    chk("rst_ovf", 64'(sel ? if1.overflow : if0.overflow), 64'd0);
    stats(sel, 32'd0, 4'd0);
  endtask
  task automatic step(input bit sel, input logic a, input logic bv, input logic [3:0] c,
                      input logic [31:0] tg, input logic [31:0] rc, input logic [31:0] pn,
                      input logic e_tk, input logic e_rd, input logic [31:0] e_pc,
                      input logic [3:0] e_m, input logic [3:0] e_d, input logic e_o);
    st_t e;
    @(negedge CLK);
    adv = a;
    br_valid = bv;
    br_cond = c;
    br_target = tg;
    br_reconv = rc;
    pc_next = pn;
    #1;
    chk("take_branch", 64'(sel ? if1.take_branch : if0.take_branch), 64'(e_tk));
    chk("redirect", 64'(sel ? if1.redirect : if0.redirect), 64'(e_rd));
    if (e_rd) chk("redirect_pc", 64'(sel ? if1.redirect_pc : if0.redirect_pc), 64'(e_pc));
    q.push_back('{e_m, e_d, e_o});
    @(posedge CLK);
    #1;
    e = q.pop_front();
    chk("mask", 64'(sel ? if1.active_mask : if0.active_mask), 64'(e.mask));
    chk("depth", sel ? 64'(if1.depth) : 64'(if0.depth), 64'(e.depth));
    chk("overflow", 64'(sel ? if1.overflow : if0.overflow), 64'(e.ovf));
    chk("empty", 64'(sel ? if1.empty : if0.empty), 64'(e.depth == 4'd0));
    chk("full", 64'(sel ? if1.full : if0.full), 64'(e.depth == (sel ? 4'd2 : 4'd8)));
  endtask
  initial begin
    do_reset(1'b0);
    step(0, 1, 1, 4'b1111, 32'h100, 32'h200, 32'h04, 1, 0, 0, 4'hF, 0, 0);
    step(0, 1, 1, 4'b0011, 32'h40, 32'h80, 32'h08, 0, 0, 0, 4'hC, 1, 0);
    step(0, 1, 0, 4'b0000, 32'h0, 32'h0, 32'h80, 0, 1, 32'h40, 4'h3, 1, 0);
    step(0, 1, 0, 4'b0000, 32'h0, 32'h0, 32'h80, 0, 0, 0, 4'hF, 0, 0);
    step(0, 1, 1, 4'b0011, 32'h40, 32'h80, 32'h10, 0, 0, 0, 4'hC, 1, 0);
    step(0, 1, 1, 4'b0100, 32'h60, 32'h70, 32'h50, 0, 0, 0, 4'h8, 2, 0);
    step(0, 1, 0, 4'b0000, 32'h0, 32'h0, 32'h70, 0, 1, 32'h60, 4'h4, 2, 0);
    step(0, 1, 0, 4'b0000, 32'h0, 32'h0, 32'h70, 0, 0, 0, 4'hC, 1, 0);
    step(0, 1, 0, 4'b0000, 32'h0, 32'h0, 32'h80, 0, 1, 32'h40, 4'h3, 1, 0);
    step(0, 1, 0, 4'b0000, 32'h0, 32'h0, 32'h80, 0, 0, 0, 4'hF, 0, 0);
    step(0, 1, 1, 4'b0101, 32'h10, 32'h20, 32'h20, 0, 1, 32'h10, 4'h5, 1, 0);
    step(0, 1, 0, 4'b0000, 32'h0, 32'h0, 32'h20, 0, 0, 0, 4'hF, 0, 0);
    step(0, 0, 1, 4'b0011, 32'h40, 32'h80, 32'h08, 0, 0, 0, 4'hF, 0, 0);
    stats(1'b0, 32'd4, 4'd2);
    do_reset(1'b1);
    step(1, 1, 1, 4'b0001, 32'h40, 32'h80, 32'h08, 0, 0, 0, 4'hE, 1, 0);
    step(1, 1, 1, 4'b0010, 32'h60, 32'h70, 32'h50, 0, 0, 0, 4'hC, 2, 0);
    step(1, 1, 1, 4'b0100, 32'h90, 32'hA0, 32'h54, 0, 0, 0, 4'hC, 2, 1);
    stats(1'b1, 32'd2, 4'd2);
    do_reset(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
